mem_ram_fifo_ctrl: RTL and testbench

- FIFO controller that turns a vendor 4x73 two-port RAM (2-cycle read latency, registered output) into a valid/ready stream FIFO for the router datapath.
- Owns write/read pointers and occupancy, and issues RAM writes and prefetch reads.
- Holds returned read data in a small output skid queue, so downstream backpressure never stalls the RAM pipeline.
- Sits between a router ingress stage and its egress arbiter; the RAM macro is instantiated alongside it, outside this block.

---
 rtl/mem_ram_fifo_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_ram_fifo_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ram_fifo_ctrl.sv
// Stream FIFO controller wrapped around an external two-port RAM with a
// fixed read latency. Returned read data lands in a small skid queue so that
// downstream backpressure never has to stall RAM reads already in flight.
module mem_ram_fifo_ctrl #(
    parameter int DATA_W   = 73,
    parameter int ADDR_W   = 2,
    parameter int DEPTH    = 4,
    parameter int RD_LAT   = 2,
    parameter int OQ_DEPTH = 3,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [CNT_W-1:0]  fill
);

    localparam int OQ_PW = (OQ_DEPTH > 1) ? $clog2(OQ_DEPTH) : 1;

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;
    logic [RD_LAT-1:0] infl_q, infl_d;
    logic [CNT_W-1:0]  infl_cnt;
    logic [OQ_PW-1:0]  oq_head_q, oq_head_d;
    logic [OQ_PW-1:0]  oq_tail_q, oq_tail_d;
    logic [CNT_W-1:0]  oq_cnt_q, oq_cnt_d;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic [DATA_W-1:0] oq_mem_q [OQ_DEPTH];
    logic              push, pop, ret, oq_we;

    function automatic logic [CNT_W-1:0] popcnt(input logic [RD_LAT-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [OQ_PW-1:0] oq_inc(input logic [OQ_PW-1:0] p);
        return (p == OQ_PW'(OQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshakes and RAM strobes; a read is only issued when the skid queue
    // has a free slot reserved for it counting every read still in flight.
    always_comb begin
        infl_cnt    = popcnt(infl_q);
        in_ready    = !rst && !flush && (ram_cnt_q < CNT_W'(DEPTH));
        ram_rd_en   = !rst && !flush && (ram_cnt_q != '0) &&
                      ((oq_cnt_q + infl_cnt) < CNT_W'(OQ_DEPTH));
        out_valid   = !rst && (oq_cnt_q != '0);
        push        = in_valid && in_ready;
        pop         = out_valid && out_ready && !flush;
        ram_wr_en   = push;
        ram_wr_addr = wptr_q;
        ram_wr_data = in_data;
        ram_rd_addr = rptr_q;
        out_data    = oq_mem_q[oq_head_q];
        fill        = rst ? '0 : fill_q;
    end

    // Next-state for pointers, counters and the in-flight shift register.
    always_comb begin
        ret       = infl_q[RD_LAT-1];
        oq_we     = ret;
        wptr_d    = push      ? wptr_q + 1'b1 : wptr_q;
        rptr_d    = ram_rd_en ? rptr_q + 1'b1 : rptr_q;
        ram_cnt_d = ram_cnt_q + CNT_W'(push) - CNT_W'(ram_rd_en);
        infl_d    = (infl_q << 1) | RD_LAT'(ram_rd_en);
        oq_tail_d = ret ? oq_inc(oq_tail_q) : oq_tail_q;
        oq_head_d = pop ? oq_inc(oq_head_q) : oq_head_q;
        oq_cnt_d  = oq_cnt_q + CNT_W'(ret) - CNT_W'(pop);
        if (flush) begin
            oq_we     = 1'b0;
            wptr_d    = '0;
            rptr_d    = '0;
            ram_cnt_d = '0;
            infl_d    = '0;
            oq_tail_d = '0;
            oq_head_d = '0;
            oq_cnt_d  = '0;
        end
        // fill is registered from next-state so it tracks the stage counts
        // of the cycle in which it is visible.
        fill_d = ram_cnt_d + popcnt(infl_d) + oq_cnt_d;
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            ram_cnt_q <= '0;
            infl_q    <= '0;
            oq_head_q <= '0;
            oq_tail_q <= '0;
            oq_cnt_q  <= '0;
            fill_q    <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ram_cnt_q <= ram_cnt_d;
            infl_q    <= infl_d;
            oq_head_q <= oq_head_d;
            oq_tail_q <= oq_tail_d;
            oq_cnt_q  <= oq_cnt_d;
            fill_q    <= fill_d;
        end
    end

    // Skid queue storage captures returning RAM data at the tail.
    always_ff @(posedge clk) begin
        if (oq_we && !rst) begin
            oq_mem_q[oq_tail_q] <= ram_rd_data;
        end
    end

endmodule

// File: tb/tb_mem_ram_fifo_ctrl.sv
// Bench for mem_ram_fifo_ctrl: a 2-cycle registered RAM model plus a
// queue-based reference of the RAM / in-flight / skid-queue word counts.
module tb_mem_ram_fifo_ctrl;

    logic         clk;
    logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [72:0]  in_data, out_data, ram_wr_data, ram_rd_data;
    logic         ram_wr_en, ram_rd_en;
    logic [1:0]   ram_wr_addr, ram_rd_addr;
    logic [3:0]   fill;

    mem_ram_fifo_ctrl #(
        .DATA_W(73), .ADDR_W(2), .DEPTH(4), .RD_LAT(2), .OQ_DEPTH(3), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .fill(fill)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM: 4 x 73, read address registered, then output registered.
    logic [72:0] ram_mem [4];
    logic [72:0] ram_s1;
    always @(posedge clk) begin
        if (ram_wr_en === 1'b1) ram_mem[ram_wr_addr] <= ram_wr_data;
        ram_s1      <= ram_mem[ram_rd_addr];
        ram_rd_data <= ram_s1;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: words held in RAM, reads in flight (with remaining
    // edges until return), skid queue contents, and write/read counts.
    logic [72:0] m_ram[$];
    logic [72:0] m_ifd[$];
    int          m_ifr[$];
    logic [72:0] m_oq[$];
    int unsigned m_wcnt, m_rcnt;
    logic [3:0]  m_fill;

    logic [157:0] obs_vec, exp_vec;
    logic         obs_in_ready, obs_out_valid, obs_rd_en, exp_push;
    logic [3:0]   obs_fill;
    logic [72:0]  out_log[$];

    task automatic step(input logic iv, input logic [72:0] d, input logic ordy,
                        input logic fl, input logic r);
        logic e_ir, e_ov, e_rd, e_pop;
        logic [72:0] e_od;
        logic [3:0]  e_fill;
        in_valid = iv; in_data = d; out_ready = ordy; flush = fl; rst = r;
        e_ir   = !r && !fl && (m_ram.size() < 4);
        e_rd   = !r && !fl && (m_ram.size() != 0) && ((m_oq.size() + m_ifd.size()) < 3);
        e_ov   = !r && (m_oq.size() != 0);
        e_od   = e_ov ? m_oq[0] : 73'b0;
        e_fill = r ? 4'd0 : m_fill;
        exp_push = iv && e_ir;
        e_pop  = e_ov && ordy && !fl;
        exp_vec = {e_ir, e_ov, e_rd, e_rd ? 2'(m_rcnt % 4) : 2'b0,
                   exp_push, exp_push ? 2'(m_wcnt % 4) : 2'b0, e_fill, e_od,
                   exp_push ? d : 73'b0};
        @(negedge clk);
        obs_vec = {in_ready, out_valid, ram_rd_en, ram_rd_en ? ram_rd_addr : 2'b0,
                   ram_wr_en, ram_wr_en ? ram_wr_addr : 2'b0, fill,
                   out_valid ? out_data : 73'b0, ram_wr_en ? ram_wr_data : 73'b0};
        obs_in_ready = in_ready; obs_out_valid = out_valid;
        obs_rd_en = ram_rd_en; obs_fill = fill;
        if (out_valid === 1'b1 && ordy && !fl && !r) out_log.push_back(out_data);
        @(posedge clk);
        if (r || fl) begin
            m_ram.delete(); m_ifd.delete(); m_ifr.delete(); m_oq.delete();
            m_wcnt = 0; m_rcnt = 0; m_fill = 4'd0;
        end else begin
            if (e_pop) void'(m_oq.pop_front());
            foreach (m_ifr[i]) m_ifr[i] = m_ifr[i] - 1;
            if (m_ifr.size() != 0 && m_ifr[0] == 0) begin
                m_oq.push_back(m_ifd.pop_front());
                void'(m_ifr.pop_front());
            end
            if (e_rd) begin
                m_ifd.push_back(m_ram.pop_front());
                m_ifr.push_back(2);
                m_rcnt++;
            end
            if (exp_push) begin
                m_ram.push_back(d);
                m_wcnt++;
            end
            m_fill = 4'(m_ram.size() + m_ifd.size() + m_oq.size());
        end
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 73'({$urandom(), $urandom(), $urandom()}), 1'b1, 1'b0, 1'b1);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL reset_vec c=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            total++;
            if ({obs_in_ready, obs_out_valid, obs_rd_en, obs_fill} !== 7'b0) begin
                bad++; $display("FAIL reset_outs got=%b want=0", {obs_in_ready, obs_out_valid, obs_rd_en, obs_fill});
            end
        end
        step(1'b0, 73'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs_in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release in_ready got=%b want=1", obs_in_ready);
        end
        out_log.delete();
    endtask

    task automatic test_single();
        logic [72:0] w = 73'h1_2345_6789_ABCD_EF01;
        int first_ov = -1, first_rd = -1;
        logic [3:0] fill5 = 4'hF;
        out_log.delete();
        for (int c = 0; c < 8; c++) begin
            step(c == 0, (c == 0) ? w : 73'b0, 1'b1, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL single_vec c=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (obs_out_valid === 1'b1 && first_ov < 0) first_ov = c;
            if (obs_rd_en === 1'b1 && first_rd < 0) first_rd = c;
            if (c == 5) fill5 = obs_fill;
        end
        total++;
        if (first_rd != 1) begin bad++; $display("FAIL single_rd_cycle got=%0d want=1", first_rd); end
        total++;
        if (first_ov != 4) begin bad++; $display("FAIL single_ov_cycle got=%0d want=4", first_ov); end
        total++;
        if (out_log.size() != 1 || out_log[0] !== w) begin
            bad++; $display("FAIL single_data count=%0d want 1 word %h", out_log.size(), w);
        end
        total++;
        if (fill5 !== 4'd0) begin bad++; $display("FAIL single_fill5 got=%0d want=0", fill5); end
    endtask

    task automatic test_fill();
        int nxt = 0, refuse = -1;
        out_log.delete();
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 73'(nxt), 1'b0, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL fill_vec c=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (obs_in_ready === 1'b0 && refuse < 0) refuse = c;
            if (exp_push) nxt++;
        end
        total++;
        if (nxt != 7) begin bad++; $display("FAIL fill_accepted got=%0d want=7", nxt); end
        total++;
        if (refuse != 7) begin bad++; $display("FAIL fill_first_refuse got=%0d want=7", refuse); end
        total++;
        if (obs_fill !== 4'd7 || obs_in_ready !== 1'b0) begin
            bad++; $display("FAIL fill_full fill=%0d in_ready=%b want 7/0", obs_fill, obs_in_ready);
        end
        for (int c = 0; c < 40; c++) begin
            step(nxt < 10, 73'(nxt), 1'b1, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL fill_drain_vec c=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (exp_push) nxt++;
        end
        total++;
        if (out_log.size() != 10) begin
            bad++; $display("FAIL fill_count got=%0d want=10", out_log.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                total++;
                if (out_log[i] !== 73'(i)) begin
                    bad++; $display("FAIL fill_order i=%0d got=%h want=%h", i, out_log[i], 73'(i));
                end
            end
        end
        total++;
        if (obs_fill !== 4'd0) begin bad++; $display("FAIL fill_end got=%0d want=0", obs_fill); end
    endtask

    task automatic test_wrap();
        int nxt = 0;
        out_log.delete();
        for (int c = 0; c < 400 && out_log.size() < 20; c++) begin
            step((nxt < 20) && ($urandom % 4 != 0), 73'(nxt), 1'($urandom % 2), 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL wrap_vec c=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (exp_push) nxt++;
        end
        total++;
        if (out_log.size() != 20) begin
            bad++; $display("FAIL wrap_count got=%0d want=20", out_log.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                total++;
                if (out_log[i] !== 73'(i)) begin
                    bad++; $display("FAIL wrap_order i=%0d got=%h want=%h", i, out_log[i], 73'(i));
                end
            end
        end
    endtask

    task automatic test_full_pop();
        int nxt = 0, streak = 0, max_streak = 0, acc = 0;
        logic [72:0] base = 73'({$urandom(), $urandom()});
        out_log.delete();
        for (int c = 0; c < 12; c++) begin
            step(1'b1, base + 73'(nxt), 1'b0, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL full_vec c=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (exp_push) nxt++;
        end
        total++;
        if (obs_fill !== 4'd7) begin bad++; $display("FAIL full_fill got=%0d want=7", obs_fill); end
        for (int c = 0; c < 24; c++) begin
            step(1'b1, base + 73'(nxt), 1'b1, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL full_pop_vec c=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (obs_in_ready === 1'b1) begin acc++; streak = 0; end
            else begin streak++; if (streak > max_streak) max_streak = streak; end
            if (exp_push) nxt++;
        end
        total++;
        if (max_streak > 2 || acc < 12) begin
            bad++; $display("FAIL full_pop_rate stall=%0d acc=%0d want stall<=2 acc>=12", max_streak, acc);
        end
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 73'b0, 1'b1, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL full_drain_vec c=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
        end
        total++;
        if (out_log.size() != nxt) begin
            bad++; $display("FAIL full_count got=%0d want=%0d", out_log.size(), nxt);
        end else begin
            for (int i = 0; i < nxt; i++) begin
                total++;
                if (out_log[i] !== base + 73'(i)) begin
                    bad++; $display("FAIL full_order i=%0d got=%h want=%h", i, out_log[i], base + 73'(i));
                end
            end
        end
    endtask

    task automatic test_flush();
        int first_ov = -1;
        out_log.delete();
        step(1'b1, 73'hA1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 73'hB2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 73'hC3, 1'b1, 1'b1, 1'b0);
        total++;
        if (obs_vec !== exp_vec) begin bad++; $display("FAIL flush_vec got=%h want=%h", obs_vec, exp_vec); end
        total++;
        if (obs_in_ready !== 1'b0 || obs_rd_en !== 1'b0) begin
            bad++; $display("FAIL flush_cycle in_ready=%b rd_en=%b want 0/0", obs_in_ready, obs_rd_en);
        end
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 73'b0, 1'b1, 1'b0, 1'b0);
            total++;
            if (obs_fill !== 4'd0 || obs_out_valid !== 1'b0) begin
                bad++; $display("FAIL flush_after c=%0d fill=%0d out_valid=%b want 0/0", c, obs_fill, obs_out_valid);
            end
        end
        for (int c = 0; c < 7; c++) begin
            step(c == 0, 73'h5A, 1'b1, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL flush_post_vec c=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (obs_out_valid === 1'b1 && first_ov < 0) first_ov = c;
        end
        total++;
        if (first_ov != 4 || out_log.size() != 1 || out_log[0] !== 73'h5A) begin
            bad++; $display("FAIL flush_post ov_cycle=%0d count=%0d want cycle 4, one word 5a", first_ov, out_log.size());
        end
    endtask

    task automatic test_reset_mid();
        int first_ov = -1;
        for (int c = 0; c < 8; c++) begin
            step(c < 5, 73'(100 + c), 1'b0, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL rstmid_vec c=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
        end
        total++;
        if (obs_fill !== 4'd5) begin bad++; $display("FAIL rstmid_pre fill got=%0d want=5", obs_fill); end
        step(1'b1, 73'h77, 1'b1, 1'b0, 1'b1);
        total++;
        if (obs_out_valid !== 1'b0 || obs_fill !== 4'd0 || obs_in_ready !== 1'b0) begin
            bad++; $display("FAIL rstmid_during ov=%b fill=%0d ir=%b want 0/0/0", obs_out_valid, obs_fill, obs_in_ready);
        end
        step(1'b0, 73'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs_in_ready !== 1'b1 || obs_fill !== 4'd0) begin
            bad++; $display("FAIL rstmid_after ir=%b fill=%0d want 1/0", obs_in_ready, obs_fill);
        end
        out_log.delete();
        for (int c = 0; c < 7; c++) begin
            step(c == 0, 73'h1, 1'b1, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL rstmid_post_vec c=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (obs_out_valid === 1'b1 && first_ov < 0) first_ov = c;
        end
        total++;
        if (first_ov != 4 || out_log.size() != 1 || out_log[0] !== 73'h1) begin
            bad++; $display("FAIL rstmid_post ov_cycle=%0d count=%0d want cycle 4, one word 1", first_ov, out_log.size());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom % 3 != 0), 73'({$urandom(), $urandom(), $urandom()}),
                 1'($urandom % 2), 1'($urandom % 32 == 0), 1'($urandom % 64 == 0));
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL random_vec c=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        m_wcnt = 0; m_rcnt = 0; m_fill = 4'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_full_pop();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
